// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesters, the shared single-port memory and mem_bus_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              mem_cs;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout;
    logic              mem_oe;
    logic [DATA_W-1:0] mem_din;
    logic              busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_din,
        output gnt0, gnt1, rvalid0, rvalid1, rdata,
        output mem_cs, mem_we, mem_addr, mem_dout, mem_oe, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_din,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata,
        input  mem_cs, mem_we, mem_addr, mem_dout, mem_oe, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter for a single-port memory: fixed priority to port 0, with a
// starvation counter that forces a port-1 grant after STARVE_LIMIT back-to-back port-0 wins.
module mem_bus_arbiter #(
    parameter int ADDR_W       = 7,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               CLK,
    input  logic               RST,
    mem_bus_arbiter_if.slave   bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        RD
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic              w_any_req;
    logic              w_pick1;
    logic              w_starved;

    assign w_any_req = bus.req0 | bus.req1;
    assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
    assign w_pick1   = bus.req1 & (~bus.req0 | w_starved);

    // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    always_comb begin
        w_next_state = r_state;
        bus.mem_cs   = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_dout = '0;
        bus.mem_oe   = 1'b0;
        bus.gnt0     = 1'b0;
        bus.gnt1     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_next_state = ACC;
                end
            end
            ACC: begin
                bus.mem_cs   = 1'b1;
                bus.mem_we   = r_we;
                bus.mem_addr = r_addr;
                bus.gnt0     = ~r_owner;
                bus.gnt1     = r_owner;
                if (r_we) begin
                    bus.mem_oe   = 1'b1;
                    bus.mem_dout = r_wdata;
                    w_next_state = IDLE;
                end else begin
                    w_next_state = RD;
                end
            end
            RD: begin
                bus.mem_cs   = 1'b1;
                bus.mem_addr = r_addr;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_owner      <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_starve_cnt <= '0;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
        end else begin
            r_rvalid0 <= (r_state == RD) & ~r_owner;
            r_rvalid1 <= (r_state == RD) & r_owner;
            if (r_state == RD) begin
                r_rdata <= bus.mem_din;
            end
            if (r_state == IDLE) begin
                if (w_any_req) begin
                    r_owner <= w_pick1;
                    r_we    <= w_pick1 ? bus.we1    : bus.we0;
                    r_addr  <= w_pick1 ? bus.addr1  : bus.addr0;
                    r_wdata <= w_pick1 ? bus.wdata1 : bus.wdata0;
                end
                // Only port-0 wins taken while port 1 is waiting count toward starvation.
                if (!bus.req1 || w_pick1) begin
                    r_starve_cnt <= '0;
                end else if (!w_starved) begin
                    r_starve_cnt <= r_starve_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.rvalid0 = r_rvalid0;
    assign bus.rvalid1 = r_rvalid1;
    assign bus.rdata   = r_rdata;
    assign bus.busy    = (r_state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a behavioural 128x32 memory on the bus.
// Every step checks outputs 1 time unit after the rising edge.
module tb_mem_bus_arbiter;

    logic CLK;
    logic RST;
    int   vectors;
    int   miscompares;
    logic [31:0] mem [0:127];
    logic [9:0]  exp_order;

    mem_bus_arbiter_if #(.ADDR_W(7), .DATA_W(32)) bus ();

    mem_bus_arbiter #(.ADDR_W(7), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign bus.mem_din = mem[bus.mem_addr];

    always @(posedge CLK) begin
        if (bus.mem_cs && bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_dout;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_order   = 10'b10_0001_0000;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[7'h20] = 32'hA5A5_0001;
        mem[7'h30] = 32'h5A5A_0002;
        mem[7'h7F] = 32'h1234_5678;
        RST = 1'b1;
        bus.req0 = 1'b0;  bus.we0 = 1'b0;  bus.addr0 = '0;  bus.wdata0 = '0;
        bus.req1 = 1'b0;  bus.we1 = 1'b0;  bus.addr1 = '0;  bus.wdata1 = '0;

        // Reset state
        step();
        step();
        check("rst_busy",   bus.busy,    0);
        check("rst_gnt0",   bus.gnt0,    0);
        check("rst_rvalid", bus.rvalid0, 0);
        check("rst_rdata",  bus.rdata,   0);
        check("rst_cs",     bus.mem_cs,  0);
        check("rst_oe",     bus.mem_oe,  0);
        RST = 1'b0;
        step();

        // Port-0 write of 0xDEADBEEF to 0x05
        bus.req0 = 1'b1;  bus.we0 = 1'b1;  bus.addr0 = 7'h05;  bus.wdata0 = 32'hDEAD_BEEF;
        step();
        check("t1_gnt0",  bus.gnt0,     1);
        check("t1_gnt1",  bus.gnt1,     0);
        check("t1_cs",    bus.mem_cs,   1);
        check("t1_we",    bus.mem_we,   1);
        check("t1_oe",    bus.mem_oe,   1);
        check("t1_addr",  bus.mem_addr, 32'h05);
        check("t1_dout",  bus.mem_dout, 32'hDEAD_BEEF);
        check("t1_busy",  bus.busy,     1);
        step();
        check("t1_idle_busy", bus.busy, 0);
        check("t1_mem05",     mem[7'h05], 32'hDEAD_BEEF);
        // Port-0 read of 0x05
        bus.we0 = 1'b0;
        step();
        check("t1r_gnt0", bus.gnt0,     1);
        check("t1r_we",   bus.mem_we,   0);
        check("t1r_oe",   bus.mem_oe,   0);
        check("t1r_dout", bus.mem_dout, 0);
        step();
        check("t1r_rd_cs",     bus.mem_cs,  1);
        check("t1r_rd_rvalid", bus.rvalid0, 0);
        step();
        check("t1r_rvalid0", bus.rvalid0, 1);
        check("t1r_rvalid1", bus.rvalid1, 0);
        check("t1r_rdata",   bus.rdata,   32'hDEAD_BEEF);
        bus.req0 = 1'b0;
        step();
        check("t1r_rvalid_pulse", bus.rvalid0, 0);
        check("t1r_rdata_hold",   bus.rdata,   32'hDEAD_BEEF);

        // Both ports read, rising together
        bus.req0 = 1'b1;  bus.we0 = 1'b0;  bus.addr0 = 7'h20;
        bus.req1 = 1'b1;  bus.we1 = 1'b0;  bus.addr1 = 7'h30;
        step();
        check("t2_gnt0", bus.gnt0,     1);
        check("t2_gnt1", bus.gnt1,     0);
        check("t2_addr", bus.mem_addr, 32'h20);
        step();
        step();
        check("t2_rvalid0",  bus.rvalid0, 1);
        check("t2_rvalid1a", bus.rvalid1, 0);
        check("t2_rdata0",   bus.rdata,   32'hA5A5_0001);
        bus.req0 = 1'b0;
        step();
        check("t2_gnt1b", bus.gnt1,     1);
        check("t2_gnt0b", bus.gnt0,     0);
        check("t2_addr1", bus.mem_addr, 32'h30);
        step();
        step();
        check("t2_rvalid1",  bus.rvalid1, 1);
        check("t2_rvalid0b", bus.rvalid0, 0);
        check("t2_rdata1",   bus.rdata,   32'h5A5A_0002);
        bus.req1 = 1'b0;
        step();

        // Both ports write continuously: starvation guard sets the order
        bus.req0 = 1'b1;  bus.we0 = 1'b1;  bus.addr0 = 7'h40;  bus.wdata0 = 32'h0000_00A0;
        bus.req1 = 1'b1;  bus.we1 = 1'b1;  bus.addr1 = 7'h41;  bus.wdata1 = 32'h0000_00B1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("t3_gnt1_%0d", i), bus.gnt1, exp_order[i]);
            check($sformatf("t3_gnt0_%0d", i), bus.gnt0, !exp_order[i]);
            check($sformatf("t3_addr_%0d", i), bus.mem_addr, exp_order[i] ? 32'h41 : 32'h40);
            step();
            check($sformatf("t3_idle_%0d", i), bus.gnt0 | bus.gnt1, 0);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        check("t3_mem40", mem[7'h40], 32'h0000_00A0);
        check("t3_mem41", mem[7'h41], 32'h0000_00B1);
        step();

        // Port-1 read alone of 0x7F
        check("t4_busy_pre", bus.busy, 0);
        bus.req1 = 1'b1;  bus.we1 = 1'b0;  bus.addr1 = 7'h7F;
        step();
        check("t4_gnt1",   bus.gnt1,   1);
        check("t4_busy1",  bus.busy,   1);
        check("t4_we_acc", bus.mem_we, 0);
        step();
        check("t4_busy2",  bus.busy,     1);
        check("t4_we_rd",  bus.mem_we,   0);
        check("t4_cs_rd",  bus.mem_cs,   1);
        check("t4_addr",   bus.mem_addr, 32'h7F);
        step();
        check("t4_rvalid1", bus.rvalid1, 1);
        check("t4_rdata",   bus.rdata,   32'h1234_5678);
        check("t4_busy3",   bus.busy,    0);
        check("t4_we_end",  bus.mem_we,  0);
        bus.req1 = 1'b0;
        step();

        // Reset during RD of a port-0 read
        bus.req0 = 1'b1;  bus.we0 = 1'b0;  bus.addr0 = 7'h05;
        step();
        check("t5_gnt0", bus.gnt0, 1);
        step();
        check("t5_rd_cs", bus.mem_cs, 1);
        RST = 1'b1;
        bus.req0 = 1'b0;
        step();
        check("t5_rvalid", bus.rvalid0, 0);
        check("t5_rdata",  bus.rdata,   0);
        check("t5_busy",   bus.busy,    0);
        RST = 1'b0;
        step();
        check("t5_rvalid_after", bus.rvalid0, 0);
        check("t5_busy_after",   bus.busy,    0);
        bus.req1 = 1'b1;  bus.we1 = 1'b0;  bus.addr1 = 7'h05;
        step();
        check("t5_gnt1", bus.gnt1, 1);
        step();
        step();
        check("t5_rvalid1", bus.rvalid1, 1);
        check("t5_rdata1",  bus.rdata,   32'hDEAD_BEEF);
        bus.req1 = 1'b0;
        step();

        // Port-0 write then immediate read of 0x10, req0 held across gnt
        bus.req0 = 1'b1;  bus.we0 = 1'b1;  bus.addr0 = 7'h10;  bus.wdata0 = 32'hCAFE_F00D;
        step();
        check("t6_gnt0_w", bus.gnt0,     1);
        check("t6_we_w",   bus.mem_we,   1);
        check("t6_addr_w", bus.mem_addr, 32'h10);
        step();
        check("t6_idle_busy", bus.busy, 0);
        check("t6_idle_gnt",  bus.gnt0, 0);
        bus.we0 = 1'b0;
        step();
        check("t6_gnt0_r", bus.gnt0,     1);
        check("t6_we_r",   bus.mem_we,   0);
        check("t6_addr_r", bus.mem_addr, 32'h10);
        step();
        step();
        check("t6_rvalid0", bus.rvalid0, 1);
        check("t6_rdata",   bus.rdata,   32'hCAFE_F00D);
        bus.req0 = 1'b0;
        step();
        check("t6_final_busy", bus.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single-port 128-word x 32-bit instruction/data memory between two requesters: port 0 (MIPS CPU, high priority) and port 1 (secondary master, e.g. I/O or display reader).
- Sequences the memory chip-select, write-enable, address and bus-drive signals. Returns read data to the winning requester.
- Fixed priority to port 0, with a starvation guard so port 1 is always serviced.

Parameters:
- ADDR_W, 7, memory word-address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive port-0 grants allowed while port 1 waits (must be at least 1)

Ports:
- CLK  in  1  system clock; all state changes on the rising edge
- RST  in  1  synchronous, active-high reset
- req0, req1  in  1 each  access request; held until the matching gnt
- we0, we1  in  1 each  1 = write, 0 = read; stable while req is high
- addr0, addr1  in  ADDR_W each  word address; stable while req is high
- wdata0, wdata1  in  DATA_W each  write data; stable while req is high
- gnt0, gnt1  out  1 each  one-cycle pulse; the request is accepted this cycle
- rvalid0, rvalid1  out  1 each  one-cycle pulse; rdata is valid for that port
- rdata  out  DATA_W  registered read data, shared by both ports
- mem_cs  out  1  memory chip select
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_dout  out  DATA_W  data driven onto the memory bus
- mem_oe  out  1  tri-state enable for mem_dout at the top level
- mem_din  in  DATA_W  memory bus read value
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (RST high at a rising edge):
  - state goes to IDLE; starve counter and owner register clear to 0.
  - All outputs go to 0, including rdata.
  - An in-flight transaction is dropped: no gnt and no rvalid follow, and memory is not written after the reset edge.
- FSM states: IDLE, ACC, RD.
- IDLE:
  - Outputs mem_cs=0, mem_oe=0.
  - Samples req0 and req1 at the edge ending the cycle. If either is high, latches the winner into the owner register plus its we/addr/wdata, then goes to ACC. Otherwise stays in IDLE.
- ACC (1 cycle):
  - mem_cs=1, mem_we=we_owner, mem_addr=addr_owner, gnt_owner=1.
  - Write: mem_oe=1, mem_dout=wdata_owner, next state IDLE.
  - Read: mem_oe=0, next state RD.
- RD (1 cycle):
  - mem_cs=1, mem_we=0, mem_addr held, mem_oe=0.
  - mem_din is captured into rdata at the edge ending RD; next state IDLE.
  - rvalid_owner=1 in the following IDLE cycle. rdata holds its value until the next read capture.
- Latency, with req first sampled high in IDLE cycle k:
  - gnt in cycle k+1.
  - Write committed at the edge ending k+1.
  - Read: rvalid and rdata in cycle k+3.
- Throughput: at least one IDLE cycle between transactions, so a write occupies 2 cycles and a read 3 cycles. The requester updates req/we/addr/wdata in the IDLE cycle after gnt.
- Arbitration:
  - If only one req is high, that port wins.
  - If both are high, port 0 wins unless starve_cnt == STARVE_LIMIT, in which case port 1 wins.
- Starve counter (width clog2(STARVE_LIMIT+1)):
  - Increments on each port-0 grant issued while req1 is high.
  - Clears on any port-1 grant, or when req1 is low in IDLE.
  - Saturates at STARVE_LIMIT.
- Simultaneous events:
  - A req rising during ACC or RD is not sampled until IDLE.
  - gnt0 and gnt1 are never high together; likewise rvalid0 and rvalid1.
- Outputs not listed for a state are 0 in that state (mem_dout = 0 when mem_oe = 0).

Test Plan:
- Reset, then port-0 write: addr0=0x05, wdata0=0xDEADBEEF, we0=1. Required: gnt0 in the cycle after the IDLE sample, with mem_cs=1, mem_we=1, mem_oe=1, mem_addr=0x05 in that cycle. Then port-0 read of 0x05: rvalid0 two cycles after gnt0, rdata=0xDEADBEEF.
- req0 and req1 both reads, rising in the same cycle. Required: gnt0 first; gnt1 three cycles later; rvalid0/rvalid1 each carry their own address's data; rvalid1 never coincides with rvalid0.
- req0 and req1 held high continuously, STARVE_LIMIT=4, all writes. Required grant order: 0,0,0,0,1,0,0,0,0,1, with a gnt every 2 cycles.
- Port-1 read alone, addr1=0x7F, memory holding 0x12345678. Required: mem_we stays 0 throughout, rdata=0x12345678 with rvalid1 at k+3, busy high for exactly 2 cycles.
- RST asserted during RD of a port-0 read. Required: no rvalid0 and rdata=0 after the reset edge, FSM in IDLE; a following port-1 request is granted normally.
- Port-0 write to 0x10 followed by an immediate port-0 read of 0x10, req0 held high across gnt. Required: 0x10 is read back; exactly one IDLE cycle between the ACC cycles; rvalid0 carries the written data.
